// File: rtl/lvdspll_phase_ctrl.sv
// Dynamic-phase-shift controller for the LVDS receiver PLL: reset/lock sequencing,
// one-step-at-a-time phase_en/updn/cntsel handshake and per-counter phase tracking.
module lvdspll_phase_ctrl #(
  parameter int N_CLK            = 5,
  parameter int CNTSEL_W         = 5,
  parameter int STEP_W           = 10,
  parameter int STEPS_PER_PERIOD = 80,
  parameter int RST_CYCLES       = 16,
  parameter int LOCK_FILTER      = 1024,
  parameter int DONE_TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic                pll_phase_en,
  output logic                pll_updn,
  output logic [CNTSEL_W-1:0] pll_cntsel,
  input  logic                pll_phase_done,
  input  logic                relock_req,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CNTSEL_W-1:0] req_cntsel,
  input  logic [STEP_W-1:0]   req_steps,
  output logic                pll_ready,
  output logic                busy,
  output logic                done,
  output logic                error,
  input  logic [CNTSEL_W-1:0] rd_sel,
  output logic [STEP_W-1:0]   rd_pos
);

  localparam int MAX_A = (LOCK_FILTER > DONE_TIMEOUT) ? LOCK_FILTER : DONE_TIMEOUT;
  localparam int MAX_T = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
  localparam int TMR_W = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, IDLE, SETUP, PULSE, WAIT_LO, WAIT_HI} state_t;

  state_t                          state, state_d;
  logic [TMR_W-1:0]                tmr_q;
  logic [CNTSEL_W-1:0]             sel_q;
  logic                            updn_q;
  logic [STEP_W-1:0]               rem_q;
  logic                            done_q, err_q;
  logic [1:0]                      lock_sync, pd_sync;
  logic                            lock_s, pd_s;
  logic [N_CLK-1:0][STEP_W-1:0]    pos_q;
  logic                            busy_st, run_st;
  logic                            tmr_clr, accept, step_ok, done_set, err_set, err_clr, pos_clr;

  // phase_done idles high, so its synchroniser resets high to avoid a false edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync <= 2'b00;
      pd_sync   <= 2'b11;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      pd_sync   <= {pd_sync[0], pll_phase_done};
    end
  end

  assign lock_s  = lock_sync[1];
  assign pd_s    = pd_sync[1];
  assign busy_st = state inside {SETUP, PULSE, WAIT_LO, WAIT_HI};
  assign run_st  = !(state inside {RST_PLL, WAIT_LOCK});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RST_PLL;
      tmr_q  <= '0;
      sel_q  <= '0;
      updn_q <= 1'b0;
      rem_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      tmr_q  <= tmr_clr ? '0 : tmr_q + TMR_W'(1);
      done_q <= done_set;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      if (accept) begin
        sel_q  <= req_cntsel;
        updn_q <= ~req_steps[STEP_W-1];
        rem_q  <= req_steps[STEP_W-1] ? STEP_W'(-req_steps) : req_steps;
      end else if (step_ok) begin
        rem_q <= rem_q - STEP_W'(1);
      end
    end
  end

  // relock > lock loss > timeout > step completion
  always_comb begin
    state_d  = state;
    tmr_clr  = 1'b0;
    accept   = 1'b0;
    step_ok  = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    pos_clr  = 1'b0;
    if (relock_req) begin
      state_d = RST_PLL;
      tmr_clr = 1'b1;
      pos_clr = 1'b1;
      if (busy_st) begin
        done_set = 1'b1;
        err_set  = 1'b1;
      end
    end else if (run_st && !lock_s) begin
      state_d = WAIT_LOCK;
      pos_clr = 1'b1;
      if (busy_st) begin
        done_set = 1'b1;
        err_set  = 1'b1;
      end
    end else begin
      case (state)
        RST_PLL:   if (tmr_q == TMR_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (!lock_s) tmr_clr = 1'b1;
          else if (tmr_q == TMR_W'(LOCK_FILTER - 1)) state_d = IDLE;
        end
        IDLE: begin
          tmr_clr = 1'b1;
          if (req_valid) begin
            accept  = 1'b1;
            err_clr = 1'b1;
            if ({1'b0, req_cntsel} >= (CNTSEL_W+1)'(N_CLK)) begin
              done_set = 1'b1;
              err_set  = 1'b1;
            end else if (req_steps == '0) begin
              done_set = 1'b1;
            end else begin
              state_d = SETUP;
            end
          end
        end
        SETUP:     state_d = PULSE;
        PULSE:     if (tmr_q == TMR_W'(1)) state_d = WAIT_LO;
        WAIT_LO: begin
          if (tmr_q == TMR_W'(DONE_TIMEOUT - 1)) begin
            state_d  = IDLE;
            done_set = 1'b1;
            err_set  = 1'b1;
          end else if (!pd_s) begin
            state_d = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tmr_q == TMR_W'(DONE_TIMEOUT - 1)) begin
            state_d  = IDLE;
            done_set = 1'b1;
            err_set  = 1'b1;
          end else if (pd_s) begin
            step_ok = 1'b1;
            if (rem_q == STEP_W'(1)) begin
              state_d  = IDLE;
              done_set = 1'b1;
            end else begin
              state_d = SETUP;
            end
          end
        end
        default:   state_d = RST_PLL;
      endcase
    end
    if (state_d != state) tmr_clr = 1'b1;

    pll_rst      = (state == RST_PLL);
    pll_phase_en = (state == PULSE);
    pll_updn     = busy_st ? updn_q : 1'b0;
    pll_cntsel   = busy_st ? sel_q : '0;
    pll_ready    = run_st;
    req_ready    = (state == IDLE) && lock_s;
    busy         = busy_st;
    done         = done_q;
    error        = err_q;
  end

  // each counter's position wraps modulo one VCO period
  for (genvar g = 0; g < N_CLK; g++) begin : g_pos
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos_q[g] <= '0;
      end else if (pos_clr) begin
        pos_q[g] <= '0;
      end else if (step_ok && sel_q == CNTSEL_W'(g)) begin
        if (updn_q)
          pos_q[g] <= (pos_q[g] == STEP_W'(STEPS_PER_PERIOD - 1)) ? '0 : pos_q[g] + STEP_W'(1);
        else
          pos_q[g] <= (pos_q[g] == '0) ? STEP_W'(STEPS_PER_PERIOD - 1) : pos_q[g] - STEP_W'(1);
      end
    end
  end

  always_comb begin
    rd_pos = '0;
    for (int i = 0; i < N_CLK; i++)
      if (rd_sel == CNTSEL_W'(i)) rd_pos = pos_q[i];
  end

endmodule

// File: tb/tb_lvdspll_phase_ctrl.sv
// Directed bench for lvdspll_phase_ctrl: request responses go through a scoreboard
// queue checked by a done-driven monitor; sequencing timings are checked inline.
module tb_lvdspll_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_phase_done = 1'b1;
  logic       relock_req = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] req_cntsel = '0;
  logic [9:0] req_steps = '0;
  logic [4:0] rd_sel = '0;
  logic       pll_rst, pll_phase_en, pll_updn, req_ready, pll_ready, busy, done, error;
  logic [4:0] pll_cntsel;
  logic [9:0] rd_pos;

  lvdspll_phase_ctrl dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .pll_phase_en(pll_phase_en), .pll_updn(pll_updn), .pll_cntsel(pll_cntsel),
    .pll_phase_done(pll_phase_done), .relock_req(relock_req), .req_valid(req_valid),
    .req_ready(req_ready), .req_cntsel(req_cntsel), .req_steps(req_steps),
    .pll_ready(pll_ready), .busy(busy), .done(done), .error(error),
    .rd_sel(rd_sel), .rd_pos(rd_pos)
  );

  typedef struct {
    bit         err;
    int         pen;
    bit         updn;
    logic [4:0] sel;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pen_cnt = 0;
  bit   hang = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever #5 clk = ~clk;

  // PLL model: answers each phase_en with a 2-cycle low phase_done 5 cycles later
  initial forever begin
    @(posedge pll_phase_en);
    if (!hang) begin
      repeat (5) @(posedge clk);
      #1 pll_phase_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 pll_phase_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (pll_phase_en) begin
        pen_cnt++;
        chk("phase_en only while a request is expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          chk("pll_updn during phase_en", pll_updn, sb_q[0].updn);
          chk("pll_cntsel during phase_en", pll_cntsel, sb_q[0].sel);
        end
      end
      if (done) begin
        chk("done has a pending request", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          chk("error at done", error, mon_e.err);
          chk("phase_en cycles per request", pen_cnt, mon_e.pen);
        end
        pen_cnt = 0;
      end
    end
  end

  task automatic send(input logic [4:0] sel, input int steps, input bit eerr, input int epen);
    exp_t e;
    int   n;
    e.err = eerr; e.pen = epen; e.updn = (steps > 0); e.sel = sel;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 3000) begin @(negedge clk); n++; end
    chk("req_ready before request", req_ready, 1);
    sb_q.push_back(e);
    req_valid = 1'b1; req_cntsel = sel; req_steps = 10'(steps);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("request completed in time", sb_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (!pll_ready && n < 3000) begin n++; @(negedge clk); end
  endtask

  task automatic check_pos(input logic [4:0] sel, input int exp, input string name);
    rd_sel = sel;
    #1 chk(name, rd_pos, exp);
  endtask

  initial begin
    int n, k;
    bit prev;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset pll_rst", pll_rst, 1);
    chk("reset pll_phase_en", pll_phase_en, 0);
    chk("reset pll_updn", pll_updn, 0);
    chk("reset pll_cntsel", pll_cntsel, 0);
    chk("reset pll_ready", pll_ready, 0);
    chk("reset req_ready", req_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    chk("reset rd_pos", rd_pos, 0);

    @(posedge clk); #1 reset_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (pll_rst && n < 100) begin n++; @(negedge clk); end
    chk("pll_rst cycles after reset", n, 16);

    repeat (3) @(posedge clk);
    #1 pll_locked = 1'b1;
    chk("pll_ready low while locking", pll_ready, 0);
    wait_ready(n);
    // 1024 filter cycles plus 2 synchroniser cycles
    chk("lock filter latency", n, 1026);
    chk("req_ready after lock", req_ready, 1);

    send(5'd2, 3, 1'b0, 6);
    wait_idle();
    chk("busy after +3 request", busy, 0);
    check_pos(5'd2, 3, "pos2 after +3");

    send(5'd0, -1, 1'b0, 2);
    wait_idle();
    check_pos(5'd0, 79, "pos0 wraps down to 79");

    send(5'd0, 2, 1'b0, 4);
    wait_idle();
    check_pos(5'd0, 1, "pos0 wraps up through 0");

    // lock drops during the 4th step of a 10-step request
    send(5'd1, 10, 1'b1, 8);
    k = 0; n = 0; prev = 1'b0;
    while (k < 4 && n < 1000) begin
      @(negedge clk);
      if (pll_phase_en && !prev) k++;
      prev = pll_phase_en;
      n++;
    end
    chk("four phase_en pulses seen", k, 4);
    @(posedge clk); #1 pll_locked = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin n++; @(negedge clk); end
    chk("abort done on lock loss", done, 1);
    chk("busy after lock loss", busy, 0);
    chk("pll_ready after lock loss", pll_ready, 0);
    chk("error after lock loss", error, 1);
    for (int i = 0; i < 5; i++) check_pos(5'(i), 0, "positions cleared on lock loss");
    @(posedge clk); #1 pll_locked = 1'b1;
    wait_ready(n);
    chk("lock filter latency after loss", n, 1026);

    // PLL never answers: timeout in WAIT_LO
    hang = 1'b1;
    send(5'd3, 2, 1'b1, 2);
    n = 0;
    while (!pll_phase_en && n < 50) begin @(negedge clk); n++; end
    while (pll_phase_en && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!done && n < 1000) begin n++; @(negedge clk); end
    chk("WAIT_LO timeout cycles", n, 255);
    chk("error on timeout", error, 1);
    check_pos(5'd3, 0, "pos3 unchanged on timeout");
    repeat (3) @(negedge clk);
    chk("error is sticky", error, 1);
    hang = 1'b0;
    send(5'd4, 1, 1'b0, 2);
    @(negedge clk);
    chk("error cleared on acceptance", error, 0);
    wait_idle();
    check_pos(5'd4, 1, "pos4 after +1");

    // out-of-range counter select
    send(5'd7, 3, 1'b1, 0);
    @(negedge clk);
    chk("done one cycle after bad cntsel", done, 1);
    chk("error on bad cntsel", error, 1);
    wait_idle();
    chk("no busy for bad cntsel", busy, 0);

    send(5'd1, 0, 1'b0, 0);
    @(negedge clk);
    chk("done for zero steps", done, 1);
    chk("error cleared by zero-step request", error, 0);
    wait_idle();

    @(posedge clk); #1 relock_req = 1'b1;
    @(posedge clk); #1 relock_req = 1'b0;
    n = 0;
    @(negedge clk);
    chk("pll_ready low after relock", pll_ready, 0);
    while (pll_rst && n < 100) begin n++; @(negedge clk); end
    chk("pll_rst cycles after relock", n, 16);
    check_pos(5'd4, 0, "pos4 cleared by relock");
    wait_ready(n);
    chk("pll_ready returns after relock", pll_ready, 1);
    chk("scoreboard drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
